// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported memory between instruction
// fetch (port 0) and the load/store unit (port 1), with a fixed access latency.
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              in_clk,
  input  logic              in_reset,
  input  logic              in_req_0,
  input  logic [DATA_W-1:0] in_addr_0,
  input  logic [DATA_W-1:0] in_wdata_0,
  input  logic              in_we_0,
  input  logic              in_req_1,
  input  logic [DATA_W-1:0] in_addr_1,
  input  logic [DATA_W-1:0] in_wdata_1,
  input  logic              in_we_1,
  input  logic [DATA_W-1:0] in_mem_rdata,
  output logic              out_mem_en,
  output logic              out_mem_we,
  output logic [DATA_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_wdata,
  output logic              out_sel,
  output logic              out_busy,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_done_0,
  output logic              out_done_1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              last_grant_q, last_grant_d;
  logic              sel_q, sel_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_0_q, done_0_d;
  logic              done_1_q, done_1_d;
  logic              winner;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    done_0_d     = 1'b0;
    done_1_d     = 1'b0;
    // On a tie the port that did not win last time gets the memory.
    winner       = (in_req_0 && in_req_1) ? ~last_grant_q : in_req_1;

    unique case (state_q)
      IDLE: begin
        if (in_req_0 || in_req_1) begin
          sel_d        = winner;
          last_grant_d = winner;
          mem_addr_d   = winner ? in_addr_1  : in_addr_0;
          mem_wdata_d  = winner ? in_wdata_1 : in_wdata_0;
          mem_we_d     = winner ? in_we_1    : in_we_0;
          mem_en_d     = 1'b1;
          count_d      = LAT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          if (!mem_we_q) begin
            rdata_d = in_mem_rdata;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          done_0_d = ~sel_q;
          done_1_d = sel_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q      <= IDLE;
      count_q      <= 4'd0;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      done_0_q     <= 1'b0;
      done_1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      done_0_q     <= done_0_d;
      done_1_q     <= done_1_d;
    end
  end

  assign out_mem_en    = mem_en_q;
  assign out_mem_we    = mem_we_q;
  assign out_mem_addr  = mem_addr_q;
  assign out_mem_wdata = mem_wdata_q;
  assign out_sel       = sel_q;
  assign out_busy      = (state_q != IDLE);
  assign out_rdata     = rdata_q;
  assign out_done_0    = done_0_q;
  assign out_done_1    = done_1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-2 instance driven by directed
// accesses, plus a latency-1 instance exercised with continuous contention.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [DW-1:0] addr0, wdata0, addr1, wdata1, mem_rdata;
  logic          mem_en, mem_we, sel, busy, done0, done1;
  logic [DW-1:0] mem_addr, mem_wdata, rdata;

  logic          b_req0, b_req1;
  logic [DW-1:0] b_mem_rdata;
  logic          b_mem_en, b_mem_we, b_sel, b_busy, b_done0, b_done1;
  logic [DW-1:0] b_mem_addr, b_mem_wdata, b_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .MEM_LATENCY(L)) dut (
    .in_clk(clk), .in_reset(rst),
    .in_req_0(req0), .in_addr_0(addr0), .in_wdata_0(wdata0), .in_we_0(we0),
    .in_req_1(req1), .in_addr_1(addr1), .in_wdata_1(wdata1), .in_we_1(we1),
    .in_mem_rdata(mem_rdata),
    .out_mem_en(mem_en), .out_mem_we(mem_we), .out_mem_addr(mem_addr),
    .out_mem_wdata(mem_wdata), .out_sel(sel), .out_busy(busy),
    .out_rdata(rdata), .out_done_0(done0), .out_done_1(done1)
  );

  mem_port_arbiter #(.DATA_W(DW), .MEM_LATENCY(1)) dut_l1 (
    .in_clk(clk), .in_reset(rst),
    .in_req_0(b_req0), .in_addr_0(32'h1), .in_wdata_0(32'h0), .in_we_0(1'b0),
    .in_req_1(b_req1), .in_addr_1(32'h2), .in_wdata_1(32'h0), .in_we_1(1'b0),
    .in_mem_rdata(b_mem_rdata),
    .out_mem_en(b_mem_en), .out_mem_we(b_mem_we), .out_mem_addr(b_mem_addr),
    .out_mem_wdata(b_mem_wdata), .out_sel(b_sel), .out_busy(b_busy),
    .out_rdata(b_rdata), .out_done_0(b_done0), .out_done_1(b_done1)
  );

  function automatic logic [DW-1:0] mem_lookup(input logic [DW-1:0] a);
    case (a)
      32'h10:  return 32'hA;
      32'h30:  return 32'hC;
      32'h40:  return 32'hD;
      default: return 32'hDEAD;
    endcase
  endfunction

  assign mem_rdata   = mem_lookup(mem_addr);
  assign b_mem_rdata = b_mem_addr + 32'h100;

  typedef struct {
    logic          port;
    logic [DW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks each access on the memory port and scores it at the done pulse.
  int            en_cnt = 0;
  logic          prev_done = 1'b0;
  logic [DW-1:0] rec_addr, rec_wdata;
  logic          rec_we;

  always @(negedge clk) begin
    if (rst) begin
      en_cnt    = 0;
      prev_done = 1'b0;
    end else begin
      check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
      check("we_without_en", {31'd0, mem_we & ~mem_en}, 32'd0);
      if (done0 || done1) begin
        check("done_one_cycle", {31'd0, prev_done}, 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done0=%0b done1=%0b, required no pulse", done0, done1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_port", {31'd0, done1}, {31'd0, e.port});
          check("sel", {31'd0, sel}, {31'd0, e.port});
          check("addr", rec_addr, e.addr);
          check("we", {31'd0, rec_we}, {31'd0, e.we});
          if (e.we) check("wdata", rec_wdata, e.wdata);
          check("rdata", rdata, e.rdata);
          check("en_cycles", en_cnt, L);
          check("en_off_at_done", {31'd0, mem_en}, 32'd0);
          check("busy_at_done", {31'd0, busy}, 32'd1);
        end
        en_cnt = 0;
      end
      if (mem_en) begin
        if (en_cnt == 0) begin
          rec_addr  = mem_addr;
          rec_wdata = mem_wdata;
          rec_we    = mem_we;
          grant_q.push_back(cyc);
          check("busy_in_access", {31'd0, busy}, 32'd1);
        end else begin
          check("addr_held", mem_addr, rec_addr);
          check("we_held", {31'd0, mem_we}, {31'd0, rec_we});
          check("wdata_held", mem_wdata, rec_wdata);
        end
        en_cnt++;
      end
      prev_done = done0 | done1;
    end
  end

  task automatic wait_done(input logic port);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (port ? done1 : done0) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_done%0d: got no done pulse, required one within 60 cycles", port);
  endtask

  task automatic wait_en();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_en) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_en: got no memory enable, required one within 60 cycles");
  endtask

  task automatic access(input logic port, input logic [DW-1:0] a, input logic w,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    sb_q.push_back('{port, a, w, wd, exp_rd});
    if (port) begin
      req1 = 1'b1; addr1 = a; we1 = w; wdata1 = wd;
    end else begin
      req0 = 1'b1; addr0 = a; we0 = w; wdata0 = wd;
    end
    wait_done(port);
    if (port) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, {31'd0, mem_en}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_sel"}, {31'd0, sel}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_done"}, {30'd0, done1, done0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, last, exp_port, b_en_cnt;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single read from port 0, then a write from port 1 that leaves rdata alone.
    access(1'b0, 32'h10, 1'b0, 32'h0, 32'hA);
    access(1'b1, 32'h20, 1'b1, 32'hB, 32'hA);

    // Continuous contention alternates grants every L+2 cycles.
    grant_q.delete();
    sb_q.push_back('{1'b0, 32'h30, 1'b0, 32'h0, 32'hC});
    sb_q.push_back('{1'b1, 32'h40, 1'b0, 32'h0, 32'hD});
    sb_q.push_back('{1'b0, 32'h30, 1'b0, 32'h0, 32'hC});
    sb_q.push_back('{1'b1, 32'h40, 1'b0, 32'h0, 32'hD});
    addr0 = 32'h30; we0 = 1'b0; addr1 = 32'h40; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(1'b0);
    wait_done(1'b1);
    wait_done(1'b0);
    wait_done(1'b1);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("tie_grant_count", grant_q.size(), 4);
    for (int i = 1; i < grant_q.size(); i++)
      check("tie_grant_spacing", grant_q[i] - grant_q[i-1], L + 2);

    // Request dropped and address changed right after the grant.
    sb_q.push_back('{1'b0, 32'h10, 1'b0, 32'h0, 32'hA});
    req0 = 1'b1; addr0 = 32'h10; we0 = 1'b0;
    wait_en();
    req0 = 1'b0; addr0 = 32'h99;
    wait_done(1'b0);
    repeat (6) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    // Reset in the middle of an access aborts it.
    req0 = 1'b1; addr0 = 32'h50;
    wait_en();
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sb_q.push_back('{1'b0, 32'h10, 1'b0, 32'h0, 32'hA});
    sb_q.push_back('{1'b1, 32'h40, 1'b0, 32'h0, 32'hD});
    addr0 = 32'h10; addr1 = 32'h40; we0 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(1'b0);
    req0 = 1'b0;
    wait_done(1'b1);
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    // Latency-1 instance under continuous contention: done every 3 cycles.
    b_req0 = 1'b1; b_req1 = 1'b1;
    nd = 0; last = 0; exp_port = 0; b_en_cnt = 0;
    for (int i = 0; i < 40 && nd < 4; i++) begin
      @(negedge clk);
      if (b_mem_en) b_en_cnt++;
      if (b_done0 || b_done1) begin
        check("l1_port", {31'd0, b_done1}, exp_port);
        check("l1_rdata", b_rdata, exp_port ? 32'h102 : 32'h101);
        check("l1_en_cycles", b_en_cnt, 1);
        if (nd > 0) check("l1_spacing", cyc - last, 3);
        last = cyc;
        nd++;
        exp_port = 1 - exp_port;
        b_en_cnt = 0;
      end
    end
    b_req0 = 1'b0; b_req1 = 1'b0;
    check("l1_done_count", nd, 4);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
